muldiv_sequencer: RTL and testbench

//  Iterative sequencer for MULT/MULTU/DIV/DIVU in the EXE stage. Takes operands from the ALU input

---
 rtl/muldiv_sequencer.sv | 160 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer for the EXE stage.
// Runs a WIDTH-step shift-add multiply or restoring divide on operand
// magnitudes, applies the result signs in FIX, and writes HI/LO once in DONE.
// It also raises the pipeline stall while an operation is in flight.
//
// Handshake: Start is a one-cycle request that is accepted only when the
// sequencer is IDLE and Flush is low. While Busy, a Start is not accepted; Stall
// holds the requester until the sequencer returns to IDLE. HILO_we is a
// single-cycle strobe, and HI/LO already hold the final values in that cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Rs_data,
  input  logic [WIDTH-1:0] Rt_data,
  input  logic             HILO_read,
  input  logic             Flush,
  output logic             Busy,
  output logic             Stall,
  output logic             HILO_we,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Div_zero,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;     // mult: multiplicand magnitude; div: divisor magnitude
  logic               is_div;
  logic               dz;       // divide by zero; acc holds {raw Rs, all ones}
  logic               neg_lo;   // negate product (mult) or quotient (div)
  logic               neg_hi;   // negate remainder (div)

  // operand decode for the accept cycle
  logic               sgn_op, rs_s, rt_s, rt_zero, accept;
  logic [WIDTH-1:0]   rs_mag, rt_mag;

  // iteration and fix-up results
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_top;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // Decode operands, one iteration step and the final sign fix-up
  always_comb begin
    sgn_op  = ~Op[0];
    rs_s    = sgn_op & Rs_data[WIDTH-1];
    rt_s    = sgn_op & Rt_data[WIDTH-1];
    rs_mag  = rs_s ? -Rs_data : Rs_data;
    rt_mag  = rt_s ? -Rt_data : Rt_data;
    rt_zero = (Rt_data == '0);
    accept  = (state == S_IDLE) & Start & ~Flush;

    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    div_top  = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_top - {1'b0, opnd};
    div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    prod   = neg_lo ? -acc : acc;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (dz) begin
      fix_hi = acc[2*WIDTH-1:WIDTH];
      fix_lo = acc[WIDTH-1:0];
    end else if (is_div) begin
      fix_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  // Next-state logic; Flush aborts only RUN and FIX
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = (Op[1] & rt_zero) ? S_FIX : S_RUN;
      S_RUN: begin
        if (Flush)                 state_n = S_IDLE;
        else if (cnt == CNT_LAST)  state_n = S_FIX;
      end
      S_FIX:  state_n = Flush ? S_IDLE : S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Operand latch, iteration datapath and HI/LO result registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          cnt    <= '0;
          is_div <= Op[1];
          dz     <= Op[1] & rt_zero;
          neg_lo <= rs_s ^ rt_s;
          neg_hi <= rs_s;
          opnd   <= Op[1] ? rt_mag : rs_mag;
          if (Op[1] & rt_zero) acc <= {Rs_data, {WIDTH{1'b1}}};
          else if (Op[1])      acc <= {{WIDTH{1'b0}}, rs_mag};
          else                 acc <= {{WIDTH{1'b0}}, rt_mag};
        end
        S_RUN: if (!Flush) begin
          cnt <= cnt + CNT_ONE;
          acc <= is_div ? div_next : mul_next;
        end
        S_FIX: if (!Flush) begin
          HI <= fix_hi;
          LO <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  // Status and strobes
  always_comb begin
    Busy      = (state != S_IDLE);
    Stall     = Busy & (HILO_read | Start);
    HILO_we   = (state == S_DONE);
    Div_zero  = (state == S_DONE) & dz;
    state_dbg = state;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer with hand-computed results.
module tb_muldiv_sequencer;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        reset, start, hilo_read, flush;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, stall, hilo_we, div_zero;
  logic [31:0] hi, lo;
  logic [1:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  muldiv_sequencer #(.WIDTH(32)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .Op(op),
    .Rs_data(rs_data), .Rt_data(rt_data), .HILO_read(hilo_read), .Flush(flush),
    .Busy(busy), .Stall(stall), .HILO_we(hilo_we), .HI(hi), .LO(lo),
    .Div_zero(div_zero), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // present an op in the current cycle (t); returns in cycle t+1 with Start low
  task automatic issue(input logic [1:0] op_v, input logic [31:0] rs, input logic [31:0] rt);
    op = op_v; rs_data = rs; rt_data = rt; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op_v, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat, input logic edz);
    int k;
    logic [63:0] e;
    exp_q.push_back({ehi, elo});
    issue(op_v, rs, rt);
    k = 1;
    while (!hilo_we && k < 60) begin
      tick();
      k++;
    end
    check({tag, "_lat"}, 64'(k), 64'(elat));
    e = exp_q.pop_front();
    check({tag, "_hi"}, {32'h0, hi}, {32'h0, e[63:32]});
    check({tag, "_lo"}, {32'h0, lo}, {32'h0, e[31:0]});
    check({tag, "_dz"}, {63'h0, div_zero}, {63'h0, edz});
    tick();
    check({tag, "_we_once"}, {63'h0, hilo_we}, 64'h0);
    check({tag, "_idle"}, {63'h0, busy}, 64'h0);
  endtask

  initial begin
    int stall_miss;
    int we_seen;
    int k;
    reset = 1'b1; start = 1'b0; hilo_read = 1'b0; flush = 1'b0;
    op = 2'b00; rs_data = '0; rt_data = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_hi", {32'h0, hi}, 64'h0);
    check("rst_lo", {32'h0, lo}, 64'h0);
    check("rst_flags", {60'h0, busy, stall, hilo_we, div_zero}, 64'h0);
    check("rst_state", {62'h0, state_dbg}, 64'h0);

    // main function
    run_op("mult_7_m3",  OP_MULT,  32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, 1'b0);
    run_op("multu_ff",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 34, 1'b0);
    run_op("mult_ff",    OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 34, 1'b0);
    run_op("divu_100_7", OP_DIVU,  32'd100, 32'd7, 32'h2, 32'hE, 34, 1'b0);
    run_op("div_m7_2",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b0);
    run_op("div_min_m1", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34, 1'b0);
    run_op("div_zero",   OP_DIV,   32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 2, 1'b1);
    run_op("divu_zero",  OP_DIVU,  32'h8000_0001, 32'h0, 32'h8000_0001, 32'hFFFF_FFFF, 2, 1'b1);

    // stall on MFHI while busy; second Start ignored
    issue(OP_MULT, 32'd3, 32'd4);
    stall_miss = 0;
    for (k = 1; k <= 35; k++) begin
      if (k > 1) tick();
      hilo_read = (k >= 5);
      start = (k == 10);
      if (k == 10) begin op = OP_MULTU; rs_data = 32'd5; rt_data = 32'd5; end
      #1;
      if (k >= 5 && k <= 34 && !stall) stall_miss++;
      if (k == 34) check("hazard_we_t34", {63'h0, hilo_we}, 64'h1);
      if (k == 35) check("hazard_stall_drop", {63'h0, stall}, 64'h0);
    end
    start = 1'b0; hilo_read = 1'b0;
    check("hazard_stall_window", 64'(stall_miss), 64'h0);
    check("hazard_result", {hi, lo}, {32'h0, 32'd12});

    // Start in the DONE cycle is stalled one cycle, then accepted
    issue(OP_DIVU, 32'd9, 32'd3);
    k = 0;
    while (!hilo_we && k < 60) begin tick(); k++; end
    op = OP_MULTU; rs_data = 32'd2; rt_data = 32'd3; start = 1'b1;
    #1;
    check("done_start_stall", {63'h0, stall}, 64'h1);
    tick();
    check("done_start_idle", {62'h0, busy, stall}, 64'h0);
    check("done_start_prev", {hi, lo}, {32'h0, 32'd3});
    tick();
    start = 1'b0;
    check("done_start_accept", {63'h0, busy}, 64'h1);
    k = 0;
    while (!hilo_we && k < 60) begin tick(); k++; end
    check("done_start_result", {hi, lo}, {32'h0, 32'd6});
    tick();

    // Flush together with Start in IDLE: nothing starts
    flush = 1'b1; start = 1'b1; op = OP_MULT; rs_data = 32'd1; rt_data = 32'd1;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_start_idle", {63'h0, busy}, 64'h0);

    // Flush mid-RUN keeps old HI/LO
    run_op("divu_142_12", OP_DIVU, 32'd142, 32'd12, 32'hA, 32'hB, 34, 1'b0);
    issue(OP_MULT, 32'd3, 32'd5);
    for (k = 0; k < 10; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", {63'h0, busy}, 64'h0);
    we_seen = 0;
    for (k = 0; k < 40; k++) begin
      if (hilo_we) we_seen++;
      tick();
    end
    check("flush_no_we", 64'(we_seen), 64'h0);
    check("flush_hilo_kept", {hi, lo}, {32'hA, 32'hB});

    // Reset mid-RUN clears HI/LO
    issue(OP_MULT, 32'd3, 32'd5);
    for (k = 0; k < 10; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_idle", {62'h0, state_dbg}, 64'h0);
    check("midrst_hilo", {hi, lo}, 64'h0);
    we_seen = 0;
    for (k = 0; k < 40; k++) begin
      if (hilo_we) we_seen++;
      tick();
    end
    check("midrst_no_we", 64'(we_seen), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
